// File: rtl/pool_requant_engine_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pool_pkg : shared types and constants for the pool/requant stage    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package pool_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      EMIT = 3'd3,
      DONE = 3'd4
   } state_t;

   // Values for the default 28x28 input map; the engine derives its own from MAPSIZE.
   localparam int DEFAULT_MAPSIZE = 28;
   localparam int OUT_DIM         = DEFAULT_MAPSIZE / 2;
   localparam int OUT_COUNT       = OUT_DIM * OUT_DIM;
   localparam int INT8_MAX        = 127;

   function automatic int out_dim_of(input int mapsize);
      return mapsize / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_requant_engine_requant_relu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | requant_relu : bias add, ReLU, rounded right shift, int8 saturation |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module requant_relu
   import pool_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic signed [31:0] max_val,
   input  logic signed [31:0] bias,
   output logic signed [7:0]  pixel
);

   logic [32:0] w_sum;
   logic [32:0] w_relu;
   logic [33:0] w_shifted;

   if (SHIFT < 0 || SHIFT > 30) begin : g_bad_shift
      $error("requant_relu: SHIFT must be in 0..30");
   end

   // 33-bit sum of two sign-extended 32-bit operands cannot overflow.
   assign w_sum  = {max_val[31], max_val} + {bias[31], bias};
   assign w_relu = w_sum[32] ? 33'd0 : w_sum;

   if (SHIFT > 0) begin : g_round
      assign w_shifted = ({1'b0, w_relu} + (34'd1 << (SHIFT - 1))) >> SHIFT;
   end else begin : g_no_round
      assign w_shifted = {1'b0, w_relu};
   end

   assign pixel = (w_shifted > 34'(INT8_MAX)) ? 8'(INT8_MAX) : w_shifted[7:0];

endmodule
`default_nettype wire

// File: rtl/pool_requant_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pool_requant_engine : 2x2 max-pool + requantise of a conv result map |
// | Revision            : 1.0                                            |
// +--------------------------------------------------------------------+
module pool_requant_engine
   import pool_pkg::*;
#(
   parameter int MAPSIZE   = 28,
   parameter int SHIFT     = 8,
   parameter int IN_ADDR_W = $clog2(MAPSIZE * MAPSIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic signed [31:0]    bias,
   output logic                  rd_en,
   output logic [IN_ADDR_W-1:0]  rd_addr,
   input  logic signed [31:0]    rd_data,
   output logic signed [7:0]     pixel_out,
   output logic                  pixel_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  all_done
);

   localparam int c_out_dim = out_dim_of(MAPSIZE);
   localparam int c_rc_w    = (c_out_dim > 1) ? $clog2(c_out_dim) : 1;
   localparam logic [c_rc_w-1:0]    c_last     = c_rc_w'(c_out_dim - 1);
   localparam logic [IN_ADDR_W-1:0] c_step_one = IN_ADDR_W'(1);
   localparam logic [IN_ADDR_W-1:0] c_step_row = IN_ADDR_W'(MAPSIZE - 1);

   if ((MAPSIZE % 2) != 0 || MAPSIZE < 2) begin : g_bad_mapsize
      $error("pool_requant_engine: MAPSIZE must be even and at least 2");
   end

   state_t                r_state;
   logic [1:0]            r_k;
   logic [c_rc_w-1:0]     r_row;
   logic [c_rc_w-1:0]     r_col;
   logic signed [31:0]    r_max;
   logic signed [31:0]    r_bias;

   logic signed [31:0]    w_max_final;
   logic signed [7:0]     w_pixel;
   logic                  w_last_col;
   logic                  w_last;
   logic [c_rc_w-1:0]     w_next_row;
   logic [c_rc_w-1:0]     w_next_col;
   logic [IN_ADDR_W-1:0]  w_next_base;

   // In WAIT the fourth word of the window is on rd_data and joins the max here.
   assign w_max_final = (rd_data > r_max) ? rd_data : r_max;

   requant_relu #(
      .SHIFT   (SHIFT)
   ) u_requant (
      .max_val (w_max_final),
      .bias    (r_bias),
      .pixel   (w_pixel)
   );

   assign w_last_col  = (r_col == c_last);
   assign w_last      = w_last_col && (r_row == c_last);
   assign w_next_col  = w_last_col ? '0 : r_col + 1'b1;
   assign w_next_row  = w_last_col ? r_row + 1'b1 : r_row;
   assign w_next_base = IN_ADDR_W'((2 * int'(w_next_row) * MAPSIZE) + (2 * int'(w_next_col)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_k         <= 2'd0;
         r_row       <= '0;
         r_col       <= '0;
         r_max       <= '0;
         r_bias      <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         pixel_out   <= '0;
         pixel_valid <= 1'b0;
         busy        <= 1'b0;
         all_done    <= 1'b0;
      end else begin
         all_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bias  <= bias;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_k     <= 2'd0;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  busy    <= 1'b1;
                  r_state <= READ;
               end
            end

            READ: begin
               // rd_data carries the word requested for sub-index r_k-1.
               if (r_k == 2'd1) begin
                  r_max <= rd_data;
               end else if (r_k != 2'd0 && rd_data > r_max) begin
                  r_max <= rd_data;
               end
               r_k <= r_k + 2'd1;
               case (r_k)
                  2'd0:    rd_addr <= rd_addr + c_step_one;
                  2'd1:    rd_addr <= rd_addr + c_step_row;
                  2'd2:    rd_addr <= rd_addr + c_step_one;
                  default: rd_addr <= rd_addr;
               endcase
               if (r_k == 2'd3) begin
                  rd_en   <= 1'b0;
                  r_state <= WAIT;
               end
            end

            WAIT: begin
               r_max       <= w_max_final;
               pixel_out   <= w_pixel;
               pixel_valid <= 1'b1;
               r_state     <= EMIT;
            end

            EMIT: begin
               if (out_ready) begin
                  pixel_valid <= 1'b0;
                  if (w_last) begin
                     r_row    <= '0;
                     r_col    <= '0;
                     all_done <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_row   <= w_next_row;
                     r_col   <= w_next_col;
                     r_k     <= 2'd0;
                     rd_en   <= 1'b1;
                     rd_addr <= w_next_base;
                     r_state <= READ;
                  end
               end
            end

            DONE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               rd_en       <= 1'b0;
               pixel_valid <= 1'b0;
               busy        <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
